// File: rtl/tpu_top.sv
// Ternary-weight matrix-vector accelerator: CPU register port, one AXI4 read burst
// for activations and weight rows, row-serial ternary MAC, one AXI4 write burst for results.
module tpu_top #(
    parameter int ARRAY_SIZE = 8,
    parameter int ACT_BITS   = 16,
    parameter int ACC_BITS   = 32
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_sel,
    input  logic        cpu_wen,
    input  logic        cpu_ren,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,

    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,

    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,

    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,

    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,

    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,

    output logic        dma_req,
    output logic        dma_wr,
    output logic [31:0] dma_addr,
    output logic [31:0] dma_wdata,
    input  logic [31:0] dma_rdata,
    input  logic        dma_ack,

    output logic        irq,
    output logic        busy,
    output logic        done
);
    // state   | meaning
    // IDLE    | waiting for a start write
    // RD_ADDR | presenting the read burst address
    // RD_DATA | receiving activations, then weight rows
    // COMPUTE | one row dot product per cycle
    // WR_ADDR | presenting the write burst address
    // WR_DATA | streaming results
    // WR_RESP | waiting for the write response
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] COMPUTE = 3'd3;
    localparam logic [2:0] WR_ADDR = 3'd4;
    localparam logic [2:0] WR_DATA = 3'd5;
    localparam logic [2:0] WR_RESP = 3'd6;

    localparam int IW = $clog2(2 * ARRAY_SIZE) + 1;
    localparam int AW = $clog2(ARRAY_SIZE);

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [IW-1:0] row_beat;
    logic [AW-1:0] slot;
    logic          irq_en;
    logic          error;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [31:0]   op_src;
    logic [31:0]   op_dst;
    logic [31:0]   cycles;
    logic          reg_wr;
    logic          reg_rd;
    logic          start;
    logic          unused_ok;

    logic signed [ACT_BITS-1:0]   act_mem [ARRAY_SIZE];
    logic        [2*ARRAY_SIZE-1:0] w_mem [ARRAY_SIZE];
    logic signed [ACC_BITS-1:0]   out_mem [ARRAY_SIZE];
    logic signed [ACC_BITS-1:0]   row_sum;

    assign reg_wr = cpu_sel & cpu_wen;
    assign reg_rd = cpu_sel & cpu_ren;
    assign start  = reg_wr && (cpu_addr[4:2] == 3'd0) && cpu_wdata[0];
    assign busy   = (state != IDLE);
    assign irq    = done & irq_en;

    // Read beats past the activations land in the weight buffer at beat-ARRAY_SIZE.
    assign row_beat = idx - IW'(ARRAY_SIZE);
    assign slot = (state == RD_DATA && idx >= IW'(ARRAY_SIZE)) ? row_beat[AW-1:0] : idx[AW-1:0];

    assign cpu_ready     = 1'b1;
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_araddr  = op_src;
    assign m_axi_arlen   = 8'(2 * ARRAY_SIZE - 1);
    assign m_axi_arsize  = 3'd2;
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = (state == RD_DATA);
    assign m_axi_awvalid = (state == WR_ADDR);
    assign m_axi_awaddr  = op_dst;
    assign m_axi_awlen   = 8'(ARRAY_SIZE - 1);
    assign m_axi_awsize  = 3'd2;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wvalid  = (state == WR_DATA);
    assign m_axi_wdata   = 32'(out_mem[slot]);
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = (state == WR_DATA) && (idx == IW'(ARRAY_SIZE - 1));
    assign m_axi_bready  = (state == WR_RESP);

    assign dma_req   = 1'b0;
    assign dma_wr    = 1'b0;
    assign dma_addr  = '0;
    assign dma_wdata = '0;

    assign unused_ok = ^{dma_rdata, dma_ack, m_axi_rlast, m_axi_rdata, cpu_addr, cpu_wdata, row_beat};

    always_comb begin
        row_sum = '0;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            case (w_mem[slot][2*c +: 2])
                2'b01:   row_sum = row_sum + ACC_BITS'(act_mem[c]);
                2'b10:   row_sum = row_sum - ACC_BITS'(act_mem[c]);
                default: row_sum = row_sum;
            endcase
        end
    end

    always_comb begin
        cpu_rdata = '0;
        if (reg_rd) begin
            case (cpu_addr[4:2])
                3'd0:    cpu_rdata = {30'b0, irq_en, 1'b0};
                3'd1:    cpu_rdata = {29'b0, error, done, busy};
                3'd2:    cpu_rdata = src_addr;
                3'd3:    cpu_rdata = dst_addr;
                3'd4:    cpu_rdata = cycles;
                3'd7:    cpu_rdata = 32'h5450_5531;
                default: cpu_rdata = '0;
            endcase
        end
    end

    // Data buffers carry no reset; every entry is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (state == RD_DATA && m_axi_rvalid) begin
            if (idx < IW'(ARRAY_SIZE))
                act_mem[slot] <= m_axi_rdata[ACT_BITS-1:0];
            else
                w_mem[slot] <= m_axi_rdata[2*ARRAY_SIZE-1:0];
        end
        if (state == COMPUTE)
            out_mem[slot] <= row_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            src_addr <= '0;
            dst_addr <= '0;
            op_src   <= '0;
            op_dst   <= '0;
            cycles   <= '0;
        end else begin
            if (reg_wr) begin
                case (cpu_addr[4:2])
                    3'd0: begin
                        irq_en <= cpu_wdata[1];
                        if (cpu_wdata[2]) begin
                            done  <= 1'b0;
                            error <= 1'b0;
                        end
                    end
                    3'd2:    src_addr <= cpu_wdata;
                    3'd3:    dst_addr <= cpu_wdata;
                    default: ;
                endcase
            end
            if (busy)
                cycles <= cycles + 32'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RD_ADDR;
                        done   <= 1'b0;
                        error  <= 1'b0;
                        cycles <= '0;
                        op_src <= src_addr;
                        op_dst <= dst_addr;
                        idx    <= '0;
                    end
                end
                RD_ADDR: if (m_axi_arready) state <= RD_DATA;
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        if (m_axi_rresp != 2'b00)
                            error <= 1'b1;
                        if (idx == IW'(2 * ARRAY_SIZE - 1)) begin
                            idx   <= '0;
                            state <= COMPUTE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (idx == IW'(ARRAY_SIZE - 1)) begin
                        idx   <= '0;
                        state <= WR_ADDR;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WR_ADDR: if (m_axi_awready) state <= WR_DATA;
                WR_DATA: begin
                    if (m_axi_wready) begin
                        if (idx == IW'(ARRAY_SIZE - 1)) begin
                            idx   <= '0;
                            state <= WR_RESP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00)
                            error <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_top.sv
// Directed bench for tpu_top: register table, table of full operations served by an
// in-bench AXI slave, plus clear, restart-while-busy and mid-operation reset sequences.
module tb_tpu_top;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_sel, cpu_wen, cpu_ren;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        irq, busy, done;

    always #5 clk = ~clk;

    tpu_top #(.ARRAY_SIZE(N), .ACT_BITS(16), .ACC_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_sel(cpu_sel), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .irq(irq), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct packed {
        logic [31:0]         src;
        logic [31:0]         dst;
        logic [N-1:0][31:0]  act;
        logic [N-1:0][15:0]  row;
        logic [N-1:0][31:0]  exp;
        logic                bp;
        logic                restart;
        logic                irq_en;
        int                  err_beat;
        int                  cycles;
    } op_vec_t;

    int errors = 0;
    int checks = 0;
    int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0;

    reg_vec_t regs_rst [7];
    op_vec_t  vecs [4];

    always @(posedge clk) begin
        if (m_axi_arvalid && m_axi_arready) ar_hs++;
        if (m_axi_awvalid && m_axi_awready) aw_hs++;
        if (m_axi_wvalid && m_axi_wready) w_hs++;
        if (m_axi_rvalid && m_axi_rready) r_hs++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s: handshake never completed", name);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cpu_sel = 0; cpu_wen = 0; cpu_ren = 0; cpu_addr = '0; cpu_wdata = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
        dma_rdata = '0; dma_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_sel = 1; cpu_wen = 1; cpu_addr = a; cpu_wdata = d;
        @(posedge clk);
        #1;
        cpu_sel = 0; cpu_wen = 0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cpu_sel = 1; cpu_ren = 1; cpu_addr = a;
        #1;
        d = cpu_rdata;
        cpu_sel = 0; cpu_ren = 0;
    endtask

    task automatic run_op(input int vi);
        op_vec_t v;
        logic [31:0] rd;
        int k, cnt, delay, b_ar, b_aw, b_w, b_r;
        bit hs;
        v = vecs[vi];
        reset_dut();
        cpu_write(32'h8, v.src);
        cpu_write(32'hC, v.dst);
        b_ar = ar_hs; b_aw = aw_hs; b_w = w_hs; b_r = r_hs;
        cpu_write(32'h0, {30'b0, v.irq_en, 1'b1});

        hs = 0; cnt = 0;
        while (!hs && cnt < 100) begin
            @(negedge clk); cnt++;
            m_axi_arready = v.bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (m_axi_arvalid && m_axi_arready) begin
                hs = 1;
                check($sformatf("op%0d araddr", vi), m_axi_araddr, v.src);
                check($sformatf("op%0d arlen/size/burst", vi),
                      {19'b0, m_axi_arlen, m_axi_arsize, m_axi_arburst}, {19'b0, 8'd15, 3'd2, 2'b01});
            end
        end
        if (!hs) timeout("ar");
        @(posedge clk); #1 m_axi_arready = 0;

        if (v.restart) begin
            cpu_write(32'h0, {30'b0, v.irq_en, 1'b1});
            check($sformatf("op%0d busy after restart", vi), {31'b0, busy}, 32'd1);
        end

        k = 0; cnt = 0;
        while (k < 2 * N && cnt < 300) begin
            @(negedge clk); cnt++;
            if (v.bp && $urandom_range(0, 2) == 0) begin
                m_axi_rvalid = 0;
            end else begin
                m_axi_rvalid = 1;
                if (k < N) m_axi_rdata = v.act[k];
                else m_axi_rdata = {16'hDEAD, v.row[k-N]};
                m_axi_rresp = (k == v.err_beat) ? 2'b10 : 2'b00;
                m_axi_rlast = (k == 2 * N - 1);
                if (m_axi_rready) k++;
            end
        end
        if (k < 2 * N) timeout("r");
        @(posedge clk); #1 m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;

        hs = 0; cnt = 0;
        while (!hs && cnt < 100) begin
            @(negedge clk); cnt++;
            m_axi_awready = v.bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (m_axi_awvalid && m_axi_awready) begin
                hs = 1;
                check($sformatf("op%0d awaddr", vi), m_axi_awaddr, v.dst);
                check($sformatf("op%0d awlen/size/burst", vi),
                      {19'b0, m_axi_awlen, m_axi_awsize, m_axi_awburst}, {19'b0, 8'd7, 3'd2, 2'b01});
            end
        end
        if (!hs) timeout("aw");
        @(posedge clk); #1 m_axi_awready = 0;

        k = 0; cnt = 0;
        while (k < N && cnt < 200) begin
            @(negedge clk); cnt++;
            m_axi_wready = v.bp ? ($urandom_range(0, 1) == 0) : 1'b1;
            if (m_axi_wvalid && m_axi_wready) begin
                check($sformatf("op%0d wdata[%0d]", vi, k), m_axi_wdata, v.exp[k]);
                check($sformatf("op%0d wstrb/wlast[%0d]", vi, k),
                      {27'b0, m_axi_wstrb, m_axi_wlast}, {27'b0, 4'hF, (k == N - 1)});
                k++;
            end
        end
        if (k < N) timeout("w");
        @(posedge clk); #1 m_axi_wready = 0;

        delay = v.bp ? int'($urandom_range(0, 4)) : 0;
        hs = 0; cnt = 0;
        while (!hs && cnt < 50) begin
            @(negedge clk); cnt++;
            m_axi_bvalid = (cnt > delay);
            m_axi_bresp = 2'b00;
            if (m_axi_bvalid && m_axi_bready) hs = 1;
        end
        if (!hs) timeout("b");
        @(posedge clk); #1 m_axi_bvalid = 0;

        cpu_read(32'h4, rd);
        check($sformatf("op%0d status", vi), rd, (v.err_beat >= 0) ? 32'd6 : 32'd2);
        check($sformatf("op%0d irq/busy/done", vi), {29'b0, irq, busy, done}, {29'b0, v.irq_en, 1'b0, 1'b1});
        check($sformatf("op%0d ar/aw bursts", vi), ar_hs - b_ar + 16 * (aw_hs - b_aw), 32'd17);
        check($sformatf("op%0d r/w beats", vi), r_hs - b_r + 256 * (w_hs - b_w), 32'd16 + 256 * 8);
        if (v.cycles != 0) begin
            cpu_read(32'h10, rd);
            check($sformatf("op%0d cycles", vi), rd, v.cycles);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int k, cnt;
        bit hs;

        regs_rst[0] = '{addr: 32'h1C, exp: 32'h5450_5531};
        regs_rst[1] = '{addr: 32'h04, exp: 32'h0};
        regs_rst[2] = '{addr: 32'h00, exp: 32'h0};
        regs_rst[3] = '{addr: 32'h08, exp: 32'h0};
        regs_rst[4] = '{addr: 32'h0C, exp: 32'h0};
        regs_rst[5] = '{addr: 32'h10, exp: 32'h0};
        regs_rst[6] = '{addr: 32'h14, exp: 32'h0};

        for (int i = 0; i < 4; i++) vecs[i] = '0;
        vecs[0].src = 32'h200; vecs[0].dst = 32'h400;
        for (int i = 0; i < N; i++) vecs[0].act[i] = 32'(i + 1);
        vecs[0].row[0] = 16'h5555; vecs[0].row[1] = 16'hAAAA; vecs[0].row[2] = 16'h0001;
        vecs[0].exp[0] = 32'd36; vecs[0].exp[1] = 32'hFFFF_FFDC; vecs[0].exp[2] = 32'd1;
        vecs[0].irq_en = 1; vecs[0].err_beat = -1; vecs[0].cycles = 35;

        vecs[1] = vecs[0];
        vecs[1].src = 32'h1000; vecs[1].dst = 32'h2000;
        vecs[1].bp = 1; vecs[1].irq_en = 0; vecs[1].cycles = 0;

        vecs[2].src = 32'h300; vecs[2].dst = 32'h500;
        vecs[2].act[0] = 32'hABCD_8000; vecs[2].act[1] = 32'h0000_FFFF;
        vecs[2].act[2] = 32'h1234_0000; vecs[2].act[7] = 32'h0000_7FFF;
        vecs[2].row[0] = 16'h0002; vecs[2].row[1] = 16'h0001; vecs[2].row[2] = 16'hFFFF;
        vecs[2].row[3] = 16'h5555; vecs[2].row[4] = 16'h8004; vecs[2].row[5] = 16'h4000;
        vecs[2].row[6] = 16'h0000; vecs[2].row[7] = 16'h0008;
        vecs[2].exp[0] = 32'h0000_8000; vecs[2].exp[1] = 32'hFFFF_8000; vecs[2].exp[2] = 32'h0;
        vecs[2].exp[3] = 32'hFFFF_FFFE; vecs[2].exp[4] = 32'hFFFF_8000; vecs[2].exp[5] = 32'h0000_7FFF;
        vecs[2].exp[6] = 32'h0;         vecs[2].exp[7] = 32'h0000_0001;
        vecs[2].irq_en = 1; vecs[2].err_beat = -1; vecs[2].cycles = 35;

        vecs[3] = vecs[0];
        vecs[3].src = 32'h600; vecs[3].dst = 32'h700;
        vecs[3].bp = 1; vecs[3].restart = 1; vecs[3].irq_en = 0; vecs[3].err_beat = 10; vecs[3].cycles = 0;

        reset_dut();
        #1;
        check("cpu_ready", {31'b0, cpu_ready}, 32'd1);
        check("reset outputs",
              {24'b0, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready, busy, done, irq}, 32'd0);
        check("dma tie-offs", {30'b0, dma_req, dma_wr} | dma_addr | dma_wdata, 32'd0);
        for (int i = 0; i < 7; i++) begin
            cpu_read(regs_rst[i].addr, rd);
            check($sformatf("reset reg 0x%02h", regs_rst[i].addr), rd, regs_rst[i].exp);
        end

        cpu_write(32'h8, 32'h1234_5678);
        cpu_write(32'hC, 32'h9ABC_DEF0);
        cpu_write(32'h14, 32'hFFFF_FFFF);
        cpu_write(32'h0, 32'h2);
        cpu_read(32'h8, rd);  check("src readback", rd, 32'h1234_5678);
        cpu_read(32'hC, rd);  check("dst readback", rd, 32'h9ABC_DEF0);
        cpu_read(32'h14, rd); check("unmapped write ignored", rd, 32'h0);
        cpu_read(32'h0, rd);  check("ctrl readback", rd, 32'h2);
        @(negedge clk);
        cpu_sel = 1; cpu_ren = 0; cpu_addr = 32'h1C; #1;
        check("rdata without ren", cpu_rdata, 32'h0);
        cpu_sel = 0;

        run_op(0);
        cpu_write(32'h0, 32'h6);
        cpu_read(32'h4, rd); check("clear status", rd, 32'h0);
        check("clear irq", {31'b0, irq}, 32'd0);
        cpu_read(32'h0, rd); check("irq_en kept", rd, 32'h2);

        for (int i = 1; i < 4; i++) run_op(i);
        cpu_write(32'h0, 32'h4);
        cpu_read(32'h4, rd); check("error cleared", rd, 32'h0);

        // Reset in the middle of the read data phase
        reset_dut();
        cpu_write(32'h8, 32'h800);
        cpu_write(32'h0, 32'h1);
        hs = 0; cnt = 0;
        while (!hs && cnt < 50) begin
            @(negedge clk); cnt++;
            m_axi_arready = 1;
            if (m_axi_arvalid) hs = 1;
        end
        if (!hs) timeout("ar mid-reset");
        @(posedge clk); #1 m_axi_arready = 0;
        k = 0; cnt = 0;
        while (k < 3 && cnt < 50) begin
            @(negedge clk); cnt++;
            m_axi_rvalid = 1; m_axi_rdata = 32'(k);
            if (m_axi_rready) k++;
        end
        if (k < 3) timeout("r mid-reset");
        @(negedge clk);
        check("pre-reset rready", {31'b0, m_axi_rready}, 32'd1);
        rst = 1;
        #1;
        check("mid reset busy/rready", {30'b0, busy, m_axi_rready}, 32'd0);
        check("mid reset valids", {29'b0, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 32'd0);
        m_axi_rvalid = 0;
        @(negedge clk);
        rst = 0;
        cpu_read(32'h4, rd); check("post reset status", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tpu_top.md
Name: tpu_top

Overview:
- Memory-mapped ternary-weight matrix-vector accelerator; sits beside the ternary CPU in the SoC.
- The CPU programs source/destination addresses and starts an operation through a simple register port.
- The block DMAs activations and ternary weights over an AXI4 read burst, computes ARRAY_SIZE dot products, and writes the results back with an AXI4 write burst.
- It then raises done and an optional interrupt.

Parameters:
- ARRAY_SIZE, 8, number of outputs, activations and weights per row (valid range 2..16).
- ACT_BITS, 16, signed activation width, taken from the low bits of each read word.
- ACC_BITS, 32, accumulator width; results wrap modulo 2^ACC_BITS; the written word is sign-extended or truncated to 32 bits.

Ports:
- clk in 1: clock; all logic on rising edge.
- rst in 1: asynchronous, active-high reset.
- cpu_sel, cpu_wen, cpu_ren in 1 each: register access strobes.
- cpu_addr in 32: byte offset; bits [4:2] select the register.
- cpu_wdata in 32 / cpu_rdata out 32: write data / combinational read data.
- cpu_ready out 1: constant 1 (zero-wait register port).
- m_axi_aw{valid out, ready in, addr out 32, len out 8, size out 3, burst out 2}: AXI write address channel.
- m_axi_w{valid out, ready in, data out 32, strb out 4, last out}: AXI write data channel.
- m_axi_b{valid in, ready out, resp in 2}: AXI write response channel.
- m_axi_ar{valid out, ready in, addr out 32, len out 8, size out 3, burst out 2}: AXI read address channel.
- m_axi_r{valid in, ready out, data in 32, resp in 2, last in}: AXI read data channel.
- dma_req, dma_wr out 1; dma_addr, dma_wdata out 32: legacy outputs, tied to 0.
- dma_rdata in 32, dma_ack in 1: legacy inputs, ignored.
- irq, busy, done out 1: status outputs.

Behaviour:
- Register map (offset in words):
  - 0 CTRL: write bit0=1 starts an operation (self-clearing); bit1 = irq_en (R/W); write bit2=1 clears done and error.
  - 1 STATUS (RO): {29'b0, error, done, busy}.
  - 2 SRC_ADDR (R/W).
  - 3 DST_ADDR (R/W).
  - 4 CYCLES (RO): clock count of the last operation.
  - 7 ID (RO): 0x54505531.
  - Other offsets read 0; writes to them are ignored.
- cpu_rdata = selected register when cpu_sel&cpu_ren, else 0.
- Writes take effect on the clock edge where cpu_sel&cpu_wen.
- Reset: all registers, the state machine and every AXI valid/ready output go to 0; busy=done=irq=0.
- State machine IDLE -> RD_ADDR -> RD_DATA -> COMPUTE -> WR_ADDR -> WR_DATA -> WR_RESP -> IDLE.
- IDLE: a start write moves to RD_ADDR on the same edge, clears done and error, zeroes CYCLES, and sets busy.
- A start write while busy is ignored.
- RD_ADDR:
  - arvalid=1, araddr=SRC_ADDR, arlen=2*ARRAY_SIZE-1, arsize=2, arburst=01.
  - Holds until arready; on handshake goes to RD_DATA with arvalid=0.
- RD_DATA:
  - rready=1.
  - Beats 0..ARRAY_SIZE-1: act[i] = rdata[ACT_BITS-1:0], signed.
  - Beats ARRAY_SIZE..2*ARRAY_SIZE-1: weight row r = beat-ARRAY_SIZE.
  - Weight w[r][c] = rdata[2c+1:2c]; 01=+1, 10=-1, 00/11=0.
  - Any rresp!=0 sets error. The beat count ends the phase, not rlast.
- COMPUTE:
  - One row per cycle, ARRAY_SIZE cycles.
  - out[r] = sum over c of w[r][c]*sext(act[c]).
  - Zero weights are skipped (no add).
- WR_ADDR: awvalid=1, awaddr=DST_ADDR, awlen=ARRAY_SIZE-1, awsize=2, awburst=01; holds until awready.
- WR_DATA:
  - wvalid=1, wdata=out[k], wstrb=4'hF, wlast=1 on beat ARRAY_SIZE-1.
  - k advances only on wvalid&wready.
- WR_RESP:
  - bready=1 until bvalid; bresp!=0 sets error.
  - Then done=1 (sticky), busy=0, return to IDLE.
- irq = done & irq_en, as a level.
- CYCLES increments every clock while busy.
- AXI valids stay asserted until their handshake and never drop early; addresses/data are stable while valid.
- Asserting rst mid-operation aborts immediately: all outputs return to reset values; buffers need not be cleared.

Test Plan:
- Reset, then read ID and STATUS -> 0x54505531, 0; cpu_ready=1; all AXI valids 0.
- ARRAY_SIZE=8, SRC=0x200, DST=0x400, start with irq_en=1:
  - acts 1..8; row0 all +1 (0x5555), row1 all -1 (0xAAAA), row2 = 0x0001, rows3-7 = 0.
  - Expect araddr 0x200 with arlen 15; writes 36, 0xFFFFFFDC, 1, 0 x5 to 0x400 with awlen 7 and wlast on beat 7.
  - done=1, irq=1, busy=0.
- Back-pressure: random arready/rready/awready/wready/bvalid delays -> identical results; each payload is transferred exactly once.
- Activation 0x8000 with weight -1 -> +32768; ACC_BITS=16 build wraps to 0x8000 sign-extended.
- Write CTRL bit2 -> done, irq and error = 0; a start write while busy -> ignored and the SRC burst is not reissued.
- Read with rresp=2'b10 on one beat -> operation completes with STATUS error=1; rst mid-RD_DATA -> busy=0, rready=0 immediately.
